// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Bit-counter width; the counter only has to reach width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             bit_d, bit_bout;
  logic             accept, last_bit;

  full_subtractor u_full_subtractor (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  assign accept   = (state_q == StIdle) && in_valid_i;
  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = bin_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        br_d   = bit_bout;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          bout_d  = bit_bout;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign diff_o = diff_q;
  assign bout_o = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during SHIFT, so keep copies for the overflow term.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a_i[WIDTH-1];
      b_msb_d = b_i[WIDTH-1];
    end
    if (last_bit) ovf_d = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_flags;
  assign unused_flags = accept ^ last_bit;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed vectors.
// Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
    bit           seen;
  } exp_t;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, bin_in, bout;
  logic [W-1:0] a_in, b_in, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .bin_i       (bin_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .bout_o      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; the top bit of the wrapped result is the borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t       m;
    logic [W:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    m.d    = full[W-1:0];
    m.bo   = full[W];
    m.ov   = (a[W-1] ^ b[W-1]) & (m.d[W-1] ^ a[W-1]);
    m.acc  = 0;
    m.seen = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
    end else begin
      check("ready_valid_exclusive", in_ready & out_valid, 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          check("model_diff", diff, q[0].d);
          check("model_bout", bout, q[0].bo);
`ifdef SERIAL_SUB_OVF_EN
          check("model_ovf", ovf, q[0].ov);
`endif
          if (!q[0].seen) begin
            check("latency", cyc - q[0].acc, W + 1);
            q[0].seen = 1'b1;
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e     = model(a_in, b_in, bin_in);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // Called at #1 after a rising edge with the DUT idle; returns the same way.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input bit lit, input logic [W-1:0] ed, input logic eb, input logic eo,
                       input int hold);
    int n;
    check("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    bin_in    = bi;
    @(posedge clk);
    #1;
    // Scramble operands after capture; hold tests also keep in_valid asserted.
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    bin_in   = 1'($urandom);
    in_valid = (hold != 0);
    n = 0;
    while (!out_valid && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", out_valid, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
        if (lit) check("hold_diff", diff, ed);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    if (lit) begin
      check("lit_diff", diff, ed);
      check("lit_bout", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      check("lit_ovf", ovf, eo);
`else
      if (eo === 1'bx) check("lit_ovf_unused", eo, 0);
`endif
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    bin_in    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(8'd100, 8'd37, 1'b0, 1, 8'd63, 1'b0, 1'b0, 0);
    do_op(8'd5, 8'd10, 1'b0, 1, 8'hFB, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 1, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b0, 1, 8'h00, 1'b0, 1'b0, 0);
    do_op(8'd77, 8'd200, 1'b1, 1, 8'd132, 1'b1, 1'b1, 5);

    // Reset abandons an operation in flight.
    in_valid = 1'b1;
    a_in     = 8'd200;
    b_in     = 8'd3;
    bin_in   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_diff", diff, 0);
    check("async_rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("async_rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(8'd20, 8'd7, 1'b0, 1, 8'd13, 1'b0, 1'b0, 0);

`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, 1, 8'h7F, 1'b0, 1'b1, 0);
    do_op(8'h7F, 8'hFF, 1'b0, 1, 8'h80, 1'b1, 1'b1, 0);
    do_op(8'h10, 8'h01, 1'b0, 1, 8'h0F, 1'b0, 1'b0, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0, '0, 1'b0, 1'b0,
            ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
